booth_multiplier_seq: RTL and testbench

//   Sequential, parametrised radix-2 Booth multiplier for the multipliers

---
 rtl/booth_multiplier_seq.sv | 111 +++++++++++
 tb/tb_booth_multiplier_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// signed or unsigned per operation, full 2*WIDTH-bit product on a start/done handshake.
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // One guard bit lets the unsigned maximum be treated as a positive signed value.
    localparam int E     = WIDTH + 1;
    localparam int CNT_W = $clog2(E + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;

    logic [E-1:0]     accReg;
    logic [E-1:0]     qReg;
    logic [E-1:0]     mReg;
    logic             qPrev;
    logic [CNT_W-1:0] cnt;

    logic [E-1:0]     sum;
    logic [E-1:0]     accShifted;
    logic [E-1:0]     qShifted;
    logic             accept;
    logic             lastStep;

    function automatic logic [E-1:0] extendOperand(input logic [WIDTH-1:0] value,
                                                   input logic             signExt);
        return {signExt & value[WIDTH-1], value};
    endfunction

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign lastStep = (cnt == CNT_W'(1));

    // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sum = accReg;
        unique case ({qReg[0], qPrev})
            2'b01:   sum = accReg + mReg;
            2'b10:   sum = accReg + ~mReg + E'(1);
            default: sum = accReg;
        endcase
        accShifted = {sum[E-1], sum[E-1:1]};
        qShifted   = {sum[0], qReg[E-1:1]};
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastStep) stateNext = DONE;
            DONE:    stateNext = start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so rst is sampled inside the clocked block and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            accReg  <= '0;
            qReg    <= '0;
            mReg    <= '0;
            qPrev   <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            accReg  <= '0;
            qReg    <= extendOperand(multiplier, is_signed);
            mReg    <= extendOperand(multiplicand, is_signed);
            qPrev   <= 1'b0;
            cnt     <= CNT_W'(E);
        end else if (state == RUN) begin
            accReg  <= accShifted;
            qReg    <= qShifted;
            qPrev   <= qReg[0];
            cnt     <= cnt - CNT_W'(1);
            // The two guard bits at the top of {A,Qr} fall outside the 2*WIDTH result.
            if (lastStep) begin
                product <= {accShifted[E-3:0], qShifted};
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed bench for booth_multiplier_seq: 8-bit vector table and handshake corners,
// plus 32-bit operations against a widened-multiply reference.
module tb_booth_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sgn8;
    logic [7:0]  mc8, mp8;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start32, sgn32;
    logic [31:0] mc32, mp32;
    logic        busy32, done32;
    logic [63:0] product32;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  m;
        logic [7:0]  q;
        logic        s;
        logic [15:0] expProd;
    } vecT;

    vecT vecs [12];

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(product8)
    );

    booth_multiplier_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32),
        .multiplicand(mc32), .multiplier(mp32),
        .busy(busy32), .done(done32), .product(product32)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Accept one 8-bit operation, scramble the operand inputs, then count edges to done.
    task automatic runOp8(input logic [7:0] m, input logic [7:0] q, input logic s,
                          input logic [15:0] expProd, input string name);
        int edges;
        @(negedge clk);
        start8 = 1'b1; mc8 = m; mp8 = q; sgn8 = s;
        @(posedge clk); #1;
        start8 = 1'b0; mc8 = ~m; mp8 = ~q; sgn8 = ~s;
        edges = 0;
        while (!done8 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({name, " latency"}, 64'(edges), 64'd9);
        check({name, " product"}, 64'(product8), 64'(expProd));
    endtask

    task automatic runOp32(input logic [31:0] m, input logic [31:0] q, input logic s, input string name);
        int          edges;
        logic [63:0] em, eq, expProd;
        em      = s ? {{32{m[31]}}, m} : {32'd0, m};
        eq      = s ? {{32{q[31]}}, q} : {32'd0, q};
        expProd = em * eq;
        @(negedge clk);
        start32 = 1'b1; mc32 = m; mp32 = q; sgn32 = s;
        @(posedge clk); #1;
        start32 = 1'b0; mc32 = ~m; mp32 = ~q;
        edges = 0;
        while (!done32 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check({name, " latency"}, 64'(edges), 64'd33);
        check({name, " product"}, product32, expProd);
    endtask

    initial begin
        int   edges;
        logic busyDropped;
        logic sawDone;

        vecs[0]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[4]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[5]  = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
        vecs[6]  = '{8'h07, 8'h06, 1'b0, 16'h002A};
        vecs[7]  = '{8'h00, 8'hFF, 1'b1, 16'h0000};
        vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[9]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[10] = '{8'hC8, 8'h64, 1'b0, 16'h4E20};
        vecs[11] = '{8'hC8, 8'h9C, 1'b1, 16'h15E0};

        rst = 1'b1;
        start8 = 1'b0; sgn8 = 1'b0; mc8 = '0; mp8 = '0;
        start32 = 1'b0; sgn32 = 1'b0; mc32 = '0; mp32 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset product8", 64'(product8), 64'd0);
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset product32", product32, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            runOp8(vecs[i].m, vecs[i].q, vecs[i].s, vecs[i].expProd, $sformatf("vec%0d", i));
        end

        // Result is held in IDLE after the done pulse.
        @(posedge clk); #1;
        check("idle after done", 64'({busy8, done8}), 64'd0);
        check("product held", 64'(product8), 64'h15E0);

        // start pulsed mid-RUN with new operands is ignored.
        @(negedge clk);
        start8 = 1'b1; mc8 = 8'hFD; mp8 = 8'h05; sgn8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        busyDropped = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            edges++;
            if (!busy8) busyDropped = 1'b1;
        end
        start8 = 1'b1; mc8 = 8'h07; mp8 = 8'h06; sgn8 = 1'b0;
        @(posedge clk); #1;
        edges++;
        start8 = 1'b0;
        if (!busy8) busyDropped = 1'b1;
        while (!done8 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (!busy8 && !done8) busyDropped = 1'b1;
        end
        check("midrun busy held", 64'(busyDropped), 64'd0);
        check("midrun latency", 64'(edges), 64'd9);
        check("midrun product", 64'(product8), 64'hFFF1);
        @(posedge clk); #1;
        check("midrun start not queued", 64'({busy8, done8}), 64'd0);

        // Back-to-back: start held in the DONE cycle skips IDLE.
        runOp8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "b2b first");
        start8 = 1'b1; mc8 = 8'h07; mp8 = 8'h06; sgn8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; mc8 = 8'h55; mp8 = 8'hAA; sgn8 = 1'b1;
        check("b2b busy immediately", 64'(busy8), 64'd1);
        check("b2b product held during run", 64'(product8), 64'hFFF1);
        edges = 0;
        while (!done8 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("b2b latency", 64'(edges), 64'd9);
        check("b2b product", 64'(product8), 64'h002A);

        // Reset at RUN edge 4 aborts the operation.
        @(negedge clk);
        start8 = 1'b1; mc8 = 8'h7F; mp8 = 8'h7F; sgn8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(busy8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        check("abort product", 64'(product8), 64'd0);
        sawDone = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 || busy8) sawDone = 1'b1;
        end
        check("abort no done pulse", 64'(sawDone), 64'd0);

        // WIDTH=32: corners then random operands.
        runOp32(32'h8000_0000, 32'h8000_0000, 1'b1, "w32 minsq signed");
        runOp32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "w32 maxsq unsigned");
        runOp32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "w32 minus1 sq");
        for (int i = 0; i < 20; i++) begin
            runOp32($urandom, $urandom, 1'($urandom_range(0, 1)), $sformatf("w32 rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
